// File: rtl/branch_predictor.sv
// branch_predictor: fetch-side direction/target predictor.
// Tagged 2-bit counter table trained by resolved branches.
module branch_predictor #(
  parameter int IDX_BITS = 4,
  parameter int CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      f_pc,
  output logic             pred_taken,
  output logic [31:0]      pred_target,
  output logic             pred_hit,
  input  logic             upd_valid,
  input  logic [31:0]      upd_pc,
  input  logic             upd_taken,
  input  logic [31:0]      upd_target,
  input  logic             upd_pred_taken,
  input  logic [31:0]      upd_pred_target,
  output logic             redirect,
  output logic [31:0]      redirect_pc,
  output logic [CNT_W-1:0] branch_count,
  output logic [CNT_W-1:0] mispredict_count
);

  localparam int N     = 1 << IDX_BITS;
  localparam int TAG_W = 30 - IDX_BITS;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      tgt;
    logic [1:0]       ctr;
  } entry_t;

  entry_t tbl_q [N];
  entry_t tbl_d [N];

  logic [IDX_BITS-1:0] f_idx;
  logic [IDX_BITS-1:0] u_idx;
  logic [TAG_W-1:0]    f_tag;
  logic [TAG_W-1:0]    u_tag;
  entry_t              f_ent;
  entry_t              u_ent;
  entry_t              u_new;
  logic                u_wr;
  logic                u_hit;
  logic                mispredict;

  logic             redirect_q;
  logic             redirect_d;
  logic [31:0]      redirect_pc_q;
  logic [31:0]      redirect_pc_d;
  logic [CNT_W-1:0] branch_count_q;
  logic [CNT_W-1:0] branch_count_d;
  logic [CNT_W-1:0] mispredict_count_q;
  logic [CNT_W-1:0] mispredict_count_d;

  assign f_idx = f_pc[IDX_BITS+1:2];
  assign f_tag = f_pc[31:IDX_BITS+2];
  assign u_idx = upd_pc[IDX_BITS+1:2];
  assign u_tag = upd_pc[31:IDX_BITS+2];
  assign f_ent = tbl_q[f_idx];
  assign u_ent = tbl_q[u_idx];
  assign u_hit = u_ent.valid && (u_ent.tag == u_tag);

  // Lookup reads the registered table only: no write bypass.
  assign pred_hit    = f_ent.valid && (f_ent.tag == f_tag);
  assign pred_taken  = pred_hit && f_ent.ctr[1];
  assign pred_target = pred_hit ? f_ent.tgt : f_pc + 32'd4;

  // A correct direction with a stale target still needs a redirect.
  assign mispredict = upd_valid &&
    ((upd_taken != upd_pred_taken) ||
     (upd_taken && upd_pred_taken &&
      (upd_target != upd_pred_target)));

  // Train the indexed entry from the resolved outcome.
  always_comb begin
    tbl_d = tbl_q;
    u_new = u_ent;
    u_wr  = 1'b0;
    unique case (1'b1)
      upd_valid && u_hit && upd_taken: begin
        u_wr      = 1'b1;
        u_new.tgt = upd_target;
        if (u_ent.ctr != 2'b11)
          u_new.ctr = u_ent.ctr + 2'b01;
      end
      upd_valid && u_hit && !upd_taken: begin
        u_wr = 1'b1;
        if (u_ent.ctr != 2'b00)
          u_new.ctr = u_ent.ctr - 2'b01;
      end
      upd_valid && !u_hit && upd_taken: begin
        u_wr        = 1'b1;
        u_new.valid = 1'b1;
        u_new.tag   = u_tag;
        u_new.tgt   = upd_target;
        u_new.ctr   = 2'b10;
      end
      default: ;
    endcase
    if (u_wr)
      tbl_d[u_idx] = u_new;
  end

  // Redirect pulse, held redirect target and wrapping counters.
  always_comb begin
    redirect_d         = mispredict;
    redirect_pc_d      = redirect_pc_q;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (mispredict) begin
      redirect_pc_d = upd_taken ? upd_target
                                : upd_pc + 32'd4;
      mispredict_count_d = mispredict_count_q + CNT_W'(1);
    end
    if (upd_valid)
      branch_count_d = branch_count_q + CNT_W'(1);
  end

  // State registers; reset discards any update in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        tbl_q[i] <= '{valid: 1'b0, tag: '0,
                      tgt: '0, ctr: 2'b01};
      redirect_q         <= 1'b0;
      redirect_pc_q      <= '0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else begin
      tbl_q              <= tbl_d;
      redirect_q         <= redirect_d;
      redirect_pc_q      <= redirect_pc_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign redirect         = redirect_q;
  assign redirect_pc      = redirect_pc_q;
  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed plus random checks
// against a table-level reference model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] f_pc;
  logic        pred_taken, pred_hit;
  logic [31:0] pred_target;
  logic        upd_valid, upd_taken, upd_pred_taken;
  logic [31:0] upd_pc, upd_target, upd_pred_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] branch_count, mispredict_count;

  logic        s_taken, s_hit, s_redirect;
  logic [31:0] s_target, s_rpc;
  logic [2:0]  s_bc, s_mc;

  always #5 clk = ~clk;

  branch_predictor dut (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_taken(pred_taken), .pred_target(pred_target),
    .pred_hit(pred_hit), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  branch_predictor #(.CNT_W(3)) dut3 (
    .clk(clk), .rst(rst), .f_pc(f_pc),
    .pred_taken(s_taken), .pred_target(s_target),
    .pred_hit(s_hit), .upd_valid(upd_valid),
    .upd_pc(upd_pc), .upd_taken(upd_taken),
    .upd_target(upd_target),
    .upd_pred_taken(upd_pred_taken),
    .upd_pred_target(upd_pred_target),
    .redirect(s_redirect), .redirect_pc(s_rpc),
    .branch_count(s_bc),
    .mispredict_count(s_mc)
  );

  bit          m_v   [16];
  int unsigned m_tag [16];
  logic [31:0] m_tgt [16];
  int          m_ctr [16];
  logic        exp_red;
  logic [31:0] exp_rpc, exp_bc, exp_mc;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin
      m_v[i]   = 1'b0;
      m_ctr[i] = 1;
      m_tag[i] = 0;
      m_tgt[i] = 32'h0;
    end
    exp_red = 1'b0;
    exp_rpc = 32'h0;
    exp_bc  = 32'h0;
    exp_mc  = 32'h0;
  endfunction

  function automatic void m_look(input logic [31:0] pc,
                                 output bit hit,
                                 output bit tk,
                                 output logic [31:0] tgt);
    int i = int'(pc[5:2]);
    int unsigned t = pc >> 6;
    hit = m_v[i] && (m_tag[i] == t);
    tk  = hit && (m_ctr[i] >= 2);
    tgt = hit ? m_tgt[i] : pc + 32'd4;
  endfunction

  function automatic void m_update();
    int i = int'(upd_pc[5:2]);
    int unsigned t = upd_pc >> 6;
    bit hit = m_v[i] && (m_tag[i] == t);
    bit mis;
    exp_red = 1'b0;
    if (!upd_valid) return;
    exp_bc = exp_bc + 1;
    mis = (upd_taken != upd_pred_taken) ||
          (upd_taken && upd_target != upd_pred_target);
    if (mis) begin
      exp_red = 1'b1;
      exp_mc  = exp_mc + 1;
      exp_rpc = upd_taken ? upd_target : upd_pc + 32'd4;
    end
    if (hit && upd_taken) begin
      m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
      m_tgt[i] = upd_target;
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
    end else if (upd_taken) begin
      m_v[i]   = 1'b1;
      m_tag[i] = t;
      m_tgt[i] = upd_target;
      m_ctr[i] = 2;
    end
  endfunction

  task automatic drive(input logic [31:0] fpc,
                       input logic v,
                       input logic [31:0] pc,
                       input logic tk,
                       input logic [31:0] tgt,
                       input logic ptk,
                       input logic [31:0] ptgt);
    f_pc            = fpc;
    upd_valid       = v;
    upd_pc          = pc;
    upd_taken       = tk;
    upd_target      = tgt;
    upd_pred_taken  = ptk;
    upd_pred_target = ptgt;
  endtask

  task automatic check_regs();
    chk("redirect", {31'h0, redirect}, {31'h0, exp_red});
    chk("redirect_pc", redirect_pc, exp_rpc);
    chk("branch_count", branch_count, exp_bc);
    chk("mispredict_count", mispredict_count, exp_mc);
    chk("bc_w3", {29'h0, s_bc}, {29'h0, exp_bc[2:0]});
    chk("mc_w3", {29'h0, s_mc}, {29'h0, exp_mc[2:0]});
  endtask

  task automatic cycle();
    bit h, t;
    logic [31:0] g;
    #1;
    m_look(f_pc, h, t, g);
    chk("pred_hit", {31'h0, pred_hit}, {31'h0, h});
    chk("pred_taken", {31'h0, pred_taken}, {31'h0, t});
    chk("pred_target", pred_target, g);
    @(posedge clk);
    m_update();
    #1;
    check_regs();
  endtask

  initial begin
    bit h, t;
    logic [31:0] g, pc, fpc, tgt;
    logic tk, ptk;
    rst = 1'b1;
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    m_reset();
    #12;
    check_regs();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: cold lookup
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t1_target", pred_target, 32'h104);

    // 2: first taken branch allocates, mispredicts
    drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    cycle();
    chk("t2_redirect", {31'h0, redirect}, 32'h1);
    chk("t2_rpc", redirect_pc, 32'h80);
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t2_pulse_end", {31'h0, redirect}, 32'h0);
    chk("t2_hit_tgt", pred_target, 32'h80);

    // 3: saturate high, then walk down
    repeat (3) begin
      drive(32'h100, 1, 32'h100, 1, 32'h80, 1, 32'h80);
      cycle();
    end
    drive(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    cycle();
    drive(32'h100, 1, 32'h100, 0, 32'h80, 1, 32'h80);
    cycle();
    chk("t3_rpc", redirect_pc, 32'h104);
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    cycle();
    chk("t3_not_taken", {31'h0, pred_taken}, 32'h0);

    // 4: aliasing at the same index
    drive(32'h140, 1, 32'h140, 1, 32'h200, 0, 32'h144);
    cycle();
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    cycle();
    drive(32'h140, 0, 0, 0, 0, 0, 0);
    cycle();

    // 5: same-cycle read/write, then stale target
    drive(32'h100, 1, 32'h100, 1, 32'h80, 0, 32'h104);
    cycle();
    drive(32'h100, 1, 32'h100, 1, 32'h300, 1, 32'h80);
    cycle();
    chk("t5_rpc", redirect_pc, 32'h300);
    drive(32'h100, 0, 0, 0, 0, 0, 0);
    cycle();

    // 6a: reset with a redirect pending and update in flight
    drive(32'h100, 1, 32'h180, 1, 32'h500, 0, 32'h184);
    cycle();
    drive(32'h100, 1, 32'h1c0, 1, 32'h600, 0, 32'h0);
    #2;
    rst = 1'b1;
    m_reset();
    #1;
    check_regs();
    m_look(f_pc, h, t, g);
    chk("rst_hit", {31'h0, pred_hit}, {31'h0, h});
    @(posedge clk);
    #1;
    upd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_regs();
    cycle();

    // 6b: narrow counter wraps
    repeat (7) begin
      drive(32'h0, 1, 32'h240, 0, 32'h0, 0, 32'h0);
      cycle();
    end
    chk("wrap_7", {29'h0, s_bc}, 32'h7);
    cycle();
    chk("wrap_0", {29'h0, s_bc}, 32'h0);

    // random traffic
    for (int n = 0; n < 400; n++) begin
      pc  = ($urandom_range(0, 3) == 0) ? 32'hffff_ffc0
                                        : 32'h1000;
      pc  = pc | ($urandom_range(0, 1) << 6)
               | ($urandom_range(0, 15) << 2)
               | $urandom_range(0, 3);
      fpc = 32'h1000 | ($urandom_range(0, 1) << 6)
                     | ($urandom_range(0, 15) << 2);
      if ($urandom_range(0, 3) == 0) fpc = pc;
      tk  = ($urandom_range(0, 2) != 0);
      tgt = 32'h2000 << $urandom_range(0, 2);
      m_look(pc, h, t, g);
      ptk = t;
      if ($urandom_range(0, 4) == 0) ptk = !ptk;
      if ($urandom_range(0, 4) == 0) g = tgt;
      drive(fpc, ($urandom_range(0, 3) != 0), pc,
            tk, tgt, ptk, g);
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
